rf_write_arbiter: RTL and testbench

//  Shares the single write port of the register file between NREQ writeback sources (ALU, load unit, ...).

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/rf_write_arbiter.sv | 98 +++++++++
 tb/tb_rf_write_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//   Definitions shared by the register file and every block that writes it.
//   RF_AWL / RF_DWL : default register address / data widths
//   rf_wr_t         : one register-file write (enable, address, data)
// -----------------------------------------------------------------------------
package rf_pkg;

   localparam int RF_AWL = 5;
   localparam int RF_DWL = 32;

   typedef struct packed {
      logic              wen;
      logic [RF_AWL-1:0] wa;
      logic [RF_DWL-1:0] wd;
   } rf_wr_t;

endpackage : rf_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker for N requesters. The scan starts at ptr,
//   wraps from N-1 back to 0, and the first asserted request wins.
//   Ports:
//     req     [N-1:0]   request vector
//     ptr     [IW-1:0]  highest-priority index this cycle (must be < N)
//     gnt     [N-1:0]   one-hot grant, zero when no request
//     gnt_idx [IW-1:0]  index of the granted requester (0 when none)
//     any               at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   // One extra bit so ptr + offset cannot overflow before the wrap.
   localparam logic [IW:0] NW = (IW+1)'(N);

   logic [IW:0] idx;

   always_comb begin
      // NOTE: every output gets a default before the loop; a path that
      // leaves one unassigned would infer a latch.
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr} + (IW+1)'(k);
         if (idx >= NW) idx = idx - NW;
         if (!any && req[idx[IW-1:0]]) begin
            any                 = 1'b1;
            gnt[idx[IW-1:0]]    = 1'b1;
            gnt_idx             = idx[IW-1:0];
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//   Shares the single register-file write port between NREQ writeback
//   sources. Round-robin, one write per cycle, valid/ready per source, and a
//   registered write stage that drives the register file directly. Writes to
//   address 0 complete their handshake but never raise rf_wen.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     stall               1 = grant nothing this cycle
//     req_valid/req_ready per-source handshake (ready one-hot or zero)
//     req_addr/req_data   source i at [i*AWL +: AWL] / [i*DWL +: DWL]
//     rf_wen/rf_wa/rf_wd  registered register-file write
//     grant_id            source of the current registered write
// -----------------------------------------------------------------------------
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter  int NREQ = 2,
   parameter  int AWL  = RF_AWL,
   parameter  int DWL  = RF_DWL,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*AWL-1:0] req_addr,
   input  logic [NREQ*DWL-1:0] req_data,
   output logic                rf_wen,
   output logic [AWL-1:0]      rf_wa,
   output logic [DWL-1:0]      rf_wd,
   output logic [IW-1:0]       grant_id
);

   // Same shape as rf_wr_t, sized by this instance's parameters.
   typedef struct packed {
      logic           wen;
      logic [AWL-1:0] wa;
      logic [DWL-1:0] wd;
   } wr_t;

   logic [IW-1:0]   rr_ptr;
   logic [NREQ-1:0] arb_gnt;
   logic [IW-1:0]   arb_idx;
   logic            arb_any;
   logic            xfer;
   logic [AWL-1:0]  win_addr;
   logic [DWL-1:0]  win_data;
   wr_t             wr_q;
   logic [IW-1:0]   gid_q;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   // Stall gates the grant, so a stalled cycle has no transfer at all.
   assign req_ready = stall ? '0 : arb_gnt;
   assign xfer      = arb_any & ~stall;
   assign win_addr  = req_addr[int'(arb_idx)*AWL +: AWL];
   assign win_data  = req_data[int'(arb_idx)*DWL +: DWL];

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + IW'(1);
      end
   end

   // Write stage: address/data/id load on every transfer (including x0),
   // enable only for non-zero addresses; otherwise only the enable drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         gid_q <= '0;
      end else if (xfer) begin
         wr_q.wen <= (win_addr != '0);
         wr_q.wa  <= win_addr;
         wr_q.wd  <= win_data;
         gid_q    <= arb_idx;
      end else begin
         wr_q.wen <= 1'b0;
      end
   end

   assign rf_wen   = wr_q.wen;
   assign rf_wa    = wr_q.wa;
   assign rf_wd    = wr_q.wd;
   assign grant_id = gid_q;

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//   Two instances: NREQ=2 for the directed scenarios, NREQ=3 for the random
//   scoreboard run. Inputs are driven on the falling edge; combinational
//   ready is sampled 1 time unit later, registered outputs 1 unit after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

   localparam int AWL = 5;
   localparam int DWL = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- NREQ = 2 instance ----------------
   logic             d2_stall;
   logic [1:0]       d2_valid, d2_ready;
   logic [2*AWL-1:0] d2_addr;
   logic [2*DWL-1:0] d2_data;
   logic             d2_wen;
   logic [AWL-1:0]   d2_wa;
   logic [DWL-1:0]   d2_wd;
   logic [0:0]       d2_gid;

   rf_write_arbiter #(.NREQ(2), .AWL(AWL), .DWL(DWL)) dut2 (
      .clk(clk), .rst_n(rst_n), .stall(d2_stall),
      .req_valid(d2_valid), .req_ready(d2_ready),
      .req_addr(d2_addr), .req_data(d2_data),
      .rf_wen(d2_wen), .rf_wa(d2_wa), .rf_wd(d2_wd), .grant_id(d2_gid)
   );

   // ---------------- NREQ = 3 instance ----------------
   logic             d3_stall;
   logic [2:0]       d3_valid, d3_ready;
   logic [3*AWL-1:0] d3_addr;
   logic [3*DWL-1:0] d3_data;
   logic             d3_wen;
   logic [AWL-1:0]   d3_wa;
   logic [DWL-1:0]   d3_wd;
   logic [1:0]       d3_gid;

   rf_write_arbiter #(.NREQ(3), .AWL(AWL), .DWL(DWL)) dut3 (
      .clk(clk), .rst_n(rst_n), .stall(d3_stall),
      .req_valid(d3_valid), .req_ready(d3_ready),
      .req_addr(d3_addr), .req_data(d3_data),
      .rf_wen(d3_wen), .rf_wa(d3_wa), .rf_wd(d3_wd), .grant_id(d3_gid)
   );

   // Reference rule: starting at ptr, wrap modulo n, first valid wins.
   function automatic int pick(input logic [2:0] v, input int ptr, input int n);
      for (int k = 0; k < n; k++) begin
         if (v[(ptr + k) % n]) return (ptr + k) % n;
      end
      return -1;
   endfunction

   int m_ptr2;   // model pointer for the NREQ=2 instance

   task automatic drive2(input logic [1:0] v, input logic [AWL-1:0] a0,
                         input logic [AWL-1:0] a1, input logic [DWL-1:0] w0,
                         input logic [DWL-1:0] w1, input logic st);
      d2_valid = v;
      d2_addr  = {a1, a0};
      d2_data  = {w1, w0};
      d2_stall = st;
   endtask

   // One NREQ=2 cycle checked against the model: ready now, write after edge.
   task automatic cycle2_check(input string tag, input logic [1:0] v,
                               input logic [AWL-1:0] a0, input logic [AWL-1:0] a1,
                               input logic [DWL-1:0] w0, input logic [DWL-1:0] w1,
                               input logic st);
      int w;
      logic [1:0] exp_rdy;
      logic [AWL-1:0] ea;
      logic [DWL-1:0] ed;
      @(negedge clk);
      drive2(v, a0, a1, w0, w1, st);
      #1;
      w       = st ? -1 : pick({1'b0, v}, m_ptr2, 2);
      exp_rdy = (w < 0) ? 2'b00 : 2'(1 << w);
      n_checks++;
      if (d2_ready !== exp_rdy) begin
         n_fail++;
         $display("FAIL %s ready: got %b expected %b", tag, d2_ready, exp_rdy);
      end
      ea = (w == 1) ? a1 : a0;
      ed = (w == 1) ? w1 : w0;
      @(posedge clk);
      #1;
      n_checks++;
      if (w >= 0) begin
         if (d2_wen !== (ea != 0) || d2_wa !== ea || d2_wd !== ed || d2_gid !== 1'(w)) begin
            n_fail++;
            $display("FAIL %s write: got wen=%b wa=%0d wd=%h id=%0d expected wen=%b wa=%0d wd=%h id=%0d",
                     tag, d2_wen, d2_wa, d2_wd, d2_gid, (ea != 0), ea, ed, w);
         end
         m_ptr2 = (w + 1) % 2;
      end else if (d2_wen !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle wen: got %b expected 0", tag, d2_wen);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      drive2(2'b11, 5'd3, 5'd4, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0);
      #1;
      n_checks++;
      if (d2_ready !== 2'b01) begin
         n_fail++; $display("FAIL reset_first_ready: got %b expected 01", d2_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (d2_wen !== 1'b1 || d2_wa !== 5'd3) begin
         n_fail++; $display("FAIL reset_inflight: got wen=%b wa=%0d expected 1/3", d2_wen, d2_wa);
      end
      // Mid-cycle reset: pointer had moved to 1, reset must bring it to 0.
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (d2_wen !== 1'b0 || d2_wa !== '0 || d2_wd !== '0 || d2_gid !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got wen=%b wa=%0d wd=%h id=%0d expected all 0",
                            d2_wen, d2_wa, d2_wd, d2_gid);
      end
      n_checks++;
      if (d2_ready !== 2'b01) begin
         n_fail++; $display("FAIL reset_ready_in_reset: got %b expected 01", d2_ready);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      m_ptr2 = 0;
      #1;
      n_checks++;
      if (d2_ready !== 2'b01) begin
         n_fail++; $display("FAIL reset_release_ready: got %b expected 01", d2_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (d2_wen !== 1'b1 || d2_gid !== 1'b0 || d2_wa !== 5'd3) begin
         n_fail++; $display("FAIL reset_first_grant: got wen=%b id=%0d wa=%0d expected 1/0/3",
                            d2_wen, d2_gid, d2_wa);
      end
      m_ptr2 = 1;
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 6; i++)
         cycle2_check("alternate", 2'b11, 5'd3, 5'd4, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         cycle2_check("back_to_back", 2'b10, 5'd0, 5'd7, 32'h0, $urandom, 1'b0);
   endtask

   task automatic test_addr0();
      // Model pointer is 0 here; x0 write completes but must not enable.
      cycle2_check("addr0", 2'b01, 5'd0, 5'd9, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
      // Pointer advanced past src0, so src1 wins with both valid.
      cycle2_check("addr0_ptr_adv", 2'b11, 5'd6, 5'd9, 32'h0000_0006, 32'h1234_5678, 1'b0);
   endtask

   task automatic test_stall();
      // Transfer in the cycle before stall, then 3 stalled cycles, then release.
      cycle2_check("pre_stall", 2'b11, 5'd3, 5'd4, 32'hCAFE_0003, 32'hCAFE_0004, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive2(2'b11, 5'd3, 5'd4, 32'hCAFE_0003, 32'hCAFE_0004, 1'b1);
         #1;
         n_checks++;
         if (d2_ready !== 2'b00) begin
            n_fail++; $display("FAIL stall_ready: got %b expected 00", d2_ready);
         end
         @(posedge clk); #1;
         n_checks++;
         if (d2_wen !== 1'b0 || d2_wa !== 5'd3 || d2_gid !== 1'b0 || d2_wd !== 32'hCAFE_0003) begin
            n_fail++; $display("FAIL stall_hold: got wen=%b wa=%0d id=%0d wd=%h expected 0/3/0/cafe0003",
                               d2_wen, d2_wa, d2_gid, d2_wd);
         end
      end
      cycle2_check("post_stall", 2'b11, 5'd3, 5'd4, 32'hCAFE_0003, 32'hCAFE_0004, 1'b0);
   endtask

   typedef struct {
      logic [AWL-1:0] a;
      logic [DWL-1:0] d;
      int             id;
   } wr_rec_t;

   task automatic test_random3();
      wr_rec_t        sb[$];
      wr_rec_t        rec;
      logic [2:0]     pend;
      logic [AWL-1:0] a[3];
      logic [DWL-1:0] d[3];
      int             wt[3];
      int             ptr, w;
      logic [2:0]     exp_rdy;
      pend = '0;
      ptr  = 0;
      for (int i = 0; i < 3; i++) begin
         wt[i] = 0; a[i] = '0; d[i] = '0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(0, 9) < 6) begin
               pend[i] = 1'b1;
               a[i]    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               d[i]    = $urandom;
               wt[i]   = 0;
            end
         end
         d3_valid = pend;
         d3_addr  = {a[2], a[1], a[0]};
         d3_data  = {d[2], d[1], d[0]};
         d3_stall = ($urandom_range(0, 9) == 0);
         #1;
         w       = d3_stall ? -1 : pick(pend, ptr, 3);
         exp_rdy = (w < 0) ? 3'b000 : 3'(1 << w);
         n_checks++;
         if (d3_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL rand_ready cyc=%0d: got %b expected %b", cyc, d3_ready, exp_rdy);
         end
         if (w >= 0) begin
            if (a[w] != 0) begin
               rec.a = a[w]; rec.d = d[w]; rec.id = w;
               sb.push_back(rec);
            end
            ptr = (w + 1) % 3;
         end
         // Source-side bookkeeping follows the DUT's handshake.
         for (int i = 0; i < 3; i++) begin
            if (pend[i] && d3_ready[i]) begin
               pend[i] = 1'b0;
            end else if (pend[i] && d3_ready != 3'b000) begin
               wt[i]++;
               n_checks++;
               if (wt[i] > 2) begin
                  n_fail++;
                  $display("FAIL rand_fairness src=%0d: waited %0d transfers, limit 2", i, wt[i]);
               end
            end
         end
         @(posedge clk); #1;
         n_checks++;
         if (d3_wen) begin
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL rand_write cyc=%0d: got unexpected write wa=%0d expected none", cyc, d3_wa);
            end else begin
               rec = sb.pop_front();
               if (d3_wa !== rec.a || d3_wd !== rec.d || d3_gid !== 2'(rec.id)) begin
                  n_fail++;
                  $display("FAIL rand_write cyc=%0d: got wa=%0d wd=%h id=%0d expected wa=%0d wd=%h id=%0d",
                           cyc, d3_wa, d3_wd, d3_gid, rec.a, rec.d, rec.id);
               end
            end
         end else if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rand_missing cyc=%0d: got wen=0 expected write wa=%0d", cyc, sb[0].a);
            sb.delete();
         end
      end
      @(negedge clk);
      d3_valid = '0;
      d3_stall = 1'b0;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL rand_drain: got %0d pending writes expected 0", sb.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive2(2'b00, '0, '0, '0, '0, 1'b0);
      d3_valid = '0; d3_addr = '0; d3_data = '0; d3_stall = 1'b0;
      m_ptr2 = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_alternate();
      test_back_to_back();
      test_addr0();
      test_stall();
      test_random3();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rf_write_arbiter
